// File: rtl/wifire_pkg.sv
// Shared definitions for the 802.15.4 receive frame controller: FSM states,
// drop reason codes, address-mode codes and header sizing.
package wifire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FILTER,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    localparam logic [2:0] DROP_NONE    = 3'd0;
    localparam logic [2:0] DROP_LEN     = 3'd1;
    localparam logic [2:0] DROP_ADDR    = 3'd2;
    localparam logic [2:0] DROP_TIMEOUT = 3'd3;
    localparam logic [2:0] DROP_LOCK    = 3'd4;

    localparam logic [1:0] AM_NONE  = 2'd0;
    localparam logic [1:0] AM_SHORT = 2'd2;
    localparam logic [1:0] AM_EXT   = 2'd3;

    localparam logic [15:0] BCAST_PAN   = 16'hFFFF;
    localparam logic [15:0] BCAST_SHORT = 16'hFFFF;

    // MAC header bytes ahead of the MSDU: fc + seq, dst pan/addr, src pan/addr.
    function automatic logic [6:0] hdr_bytes(input logic [15:0] fc);
        logic [6:0] h;
        h = 7'd3;
        case (fc[11:10])
            AM_SHORT: h = h + 7'd4;
            AM_EXT:   h = h + 7'd10;
            default:  h = h;
        endcase
        case (fc[15:14])
            AM_SHORT: h = h + 7'd2;
            AM_EXT:   h = h + 7'd8;
            default:  h = h;
        endcase
        if (fc[15:14] != AM_NONE && !fc[6])
            h = h + 7'd2;
        return h;
    endfunction

endpackage

// File: rtl/wifire_addr_filter.sv
// Combinational destination PAN/address filter for received frames.
module wifire_addr_filter
    import wifire_pkg::*;
(
    input  logic [15:0] fc,
    input  logic [15:0] dst_pan,
    input  logic [63:0] dst_addr,
    input  logic        promisc,
    input  logic [15:0] own_pan,
    input  logic [15:0] own_short,
    input  logic [63:0] own_ext,
    output logic        pass
);

    logic pan_ok;
    logic addr_ok;

    assign pan_ok = (dst_pan == own_pan) || (dst_pan == BCAST_PAN);

    always_comb begin
        addr_ok = 1'b0;
        case (fc[11:10])
            AM_SHORT: addr_ok = (dst_addr[15:0] == own_short) || (dst_addr[15:0] == BCAST_SHORT);
            AM_EXT:   addr_ok = (dst_addr == own_ext);
            default:  addr_ok = 1'b0;
        endcase
    end

    assign pass = promisc || (fc[11:10] == AM_NONE) || (pan_ok && addr_ok);

endmodule

// File: rtl/wifire_rx_frame_ctrl.sv
// Frame-level sequencer: tracks each frame from SFD to last MSDU byte, filters,
// length-checks, times out, and reports done/drop pulses with saturating stats.
module wifire_rx_frame_ctrl
    import wifire_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYC = 20'd400000,
    parameter int          CNT_W       = 16
) (
    input  logic             dsp_clk,
    input  logic             reset,
    input  logic             cfg_enable_i,
    input  logic             cfg_promisc_i,
    input  logic [15:0]      cfg_pan_i,
    input  logic [15:0]      cfg_short_i,
    input  logic [63:0]      cfg_ext_i,
    input  logic             rcv_sfd_i,
    input  logic             rcv_running_i,
    input  logic [6:0]       dec_len_i,
    input  logic [15:0]      dec_frame_ctrl_i,
    input  logic [15:0]      dec_dst_pan_i,
    input  logic [63:0]      dec_dst_addr_i,
    input  logic             dec_valid_len_i,
    input  logic             dec_valid_fc_i,
    input  logic             dec_valid_addr_i,
    input  logic             dec_msdu_stb_i,
    input  logic [7:0]       dec_msdu_pos_i,
    output logic             dec_en_o,
    output logic [6:0]       payload_len_o,
    output logic             accept_o,
    output logic             frame_start_o,
    output logic             frame_done_o,
    output logic             frame_drop_o,
    output logic [2:0]       drop_reason_o,
    output logic [CNT_W-1:0] cnt_ok_o,
    output logic [CNT_W-1:0] cnt_drop_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [19:0]      TMO_LAST = TIMEOUT_CYC - 20'd1;

    state_t      state;
    logic        fc_seen;
    logic [6:0]  hdr_r;
    logic [19:0] timer;
    logic        pass;
    logic        in_frame;
    logic        last_byte;
    logic [2:0]  drop_code;

    wifire_addr_filter u_filter (
        .fc        (dec_frame_ctrl_i),
        .dst_pan   (dec_dst_pan_i),
        .dst_addr  (dec_dst_addr_i),
        .promisc   (cfg_promisc_i),
        .own_pan   (cfg_pan_i),
        .own_short (cfg_short_i),
        .own_ext   (cfg_ext_i),
        .pass      (pass)
    );

    assign in_frame  = (state == ST_HDR) || (state == ST_FILTER) || (state == ST_PAYLOAD);
    assign last_byte = (state == ST_PAYLOAD) && dec_msdu_stb_i &&
                       (dec_msdu_pos_i == {1'b0, payload_len_o - 7'd1});

    // Lost lock outranks timeout, which outranks the per-state checks.
    always_comb begin
        drop_code = DROP_NONE;
        if (in_frame && !rcv_running_i)
            drop_code = DROP_LOCK;
        else if (in_frame && timer == TMO_LAST)
            drop_code = DROP_TIMEOUT;
        else if (state == ST_HDR && !fc_seen && dec_valid_fc_i &&
                 dec_len_i < hdr_bytes(dec_frame_ctrl_i) + 7'd2)
            drop_code = DROP_LEN;
        else if (state == ST_FILTER && !pass)
            drop_code = DROP_ADDR;
    end

    always_ff @(posedge dsp_clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            fc_seen       <= 1'b0;
            hdr_r         <= '0;
            timer         <= '0;
            dec_en_o      <= 1'b0;
            payload_len_o <= '0;
            accept_o      <= 1'b0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_drop_o  <= 1'b0;
            drop_reason_o <= DROP_NONE;
            cnt_ok_o      <= '0;
            cnt_drop_o    <= '0;
        end else begin
            dec_en_o      <= cfg_enable_i;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_drop_o  <= 1'b0;
            if (!cfg_enable_i) begin
                state    <= ST_IDLE;
                accept_o <= 1'b0;
                timer    <= '0;
            end else if (rcv_sfd_i) begin
                // A new SFD silently abandons whatever frame was in flight.
                state         <= ST_HDR;
                fc_seen       <= 1'b0;
                timer         <= '0;
                accept_o      <= 1'b0;
                frame_start_o <= 1'b1;
                drop_reason_o <= DROP_NONE;
            end else if (drop_code != DROP_NONE) begin
                state         <= ST_DROP;
                accept_o      <= 1'b0;
                frame_drop_o  <= 1'b1;
                drop_reason_o <= drop_code;
                if (cnt_drop_o != CNT_MAX)
                    cnt_drop_o <= cnt_drop_o + 1'b1;
            end else begin
                if (in_frame)
                    timer <= timer + 20'd1;
                case (state)
                    ST_HDR: begin
                        if (!fc_seen && dec_valid_fc_i) begin
                            fc_seen <= 1'b1;
                            hdr_r   <= hdr_bytes(dec_frame_ctrl_i);
                        end else if (fc_seen && dec_valid_addr_i) begin
                            state         <= ST_FILTER;
                            payload_len_o <= dec_len_i - hdr_r;
                        end
                    end
                    ST_FILTER: begin
                        state    <= ST_PAYLOAD;
                        accept_o <= 1'b1;
                    end
                    ST_PAYLOAD: begin
                        if (last_byte) begin
                            state        <= ST_IDLE;
                            accept_o     <= 1'b0;
                            frame_done_o <= 1'b1;
                            if (cnt_ok_o != CNT_MAX)
                                cnt_ok_o <= cnt_ok_o + 1'b1;
                        end
                    end
                    ST_DROP: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
